// File: rtl/instr_issue_unit_if.sv
// Loader/issue bundle for instr_issue_unit: buffer fill handshake, issue enable,
// issued instruction and status counters.
interface instr_issue_unit_if #(
    parameter int unsigned FIFO_DEPTH = 8
) ();
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             in_valid;
    logic [31:0]      in_instr;
    logic             in_ready;
    logic             run;
    logic [31:0]      instr_out;
    logic             issue_valid;
    logic [CNT_W-1:0] fifo_count;
    logic [15:0]      issued_count;
    logic [15:0]      stall_count;

    modport master (
        output in_valid, in_instr, run,
        input  in_ready, instr_out, issue_valid, fifo_count, issued_count, stall_count
    );

    modport slave (
        input  in_valid, in_instr, run,
        output in_ready, instr_out, issue_valid, fifo_count, issued_count, stall_count
    );
endinterface

// File: rtl/instr_issue_unit.sv
// In-order instruction issue: buffers loader instructions in a FIFO and issues the head
// each cycle unless it reads a register written within the last HAZ_DIST-1 issue slots.
module instr_issue_unit #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned HAZ_DIST   = 3
) (
    input  logic               clk,
    input  logic               rst,
    instr_issue_unit_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SB_N  = HAZ_DIST - 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]      BUBBLE   = 32'h0000_0000;
    localparam logic [15:0]      CNT_MAX  = 16'hFFFF;

    logic [31:0]          mem_q [FIFO_DEPTH];
    logic [31:0]          mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [SB_N-1:0]      sb_vld_q, sb_vld_d;
    logic [SB_N-1:0][4:0] sb_ws_q, sb_ws_d;
    logic [31:0]          instr_out_q, instr_out_d;
    logic                 issue_valid_q, issue_valid_d;
    logic [15:0]          issued_q, issued_d;
    logic [15:0]          stall_q, stall_d;

    logic        full, empty, push, pop, stall_evt, hazard;
    logic [31:0] head;
    logic [4:0]  rs1, rs2;
    logic        data_src;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign head     = mem_q[rd_ptr_q];
    assign data_src = head[28];
    assign rs1      = head[21:17];
    assign rs2      = head[16:12];

    // Slot 0 holds the most recent issue slot; any valid match means the writer is too close.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < int'(SB_N); i++) begin
            if (sb_vld_q[i] && ((sb_ws_q[i] == rs1) || (!data_src && (sb_ws_q[i] == rs2)))) begin
                hazard = 1'b1;
            end
        end
    end

    // Ready is taken from the pre-pop occupancy, so a full buffer refuses even while draining.
    assign push      = bus.in_valid && !full;
    assign pop       = bus.run && !empty && !hazard;
    assign stall_evt = bus.run && !empty && hazard;

    always_comb begin
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        sb_vld_d      = sb_vld_q;
        sb_ws_d       = sb_ws_q;
        instr_out_d   = BUBBLE;
        issue_valid_d = 1'b0;
        issued_d      = issued_q;
        stall_d       = stall_q;

        if (push) begin
            mem_d[wr_ptr_q] = bus.in_instr;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        for (int i = int'(SB_N) - 1; i > 0; i--) begin
            sb_vld_d[i] = sb_vld_q[i-1];
            sb_ws_d[i]  = sb_ws_q[i-1];
        end
        sb_vld_d[0] = pop && head[27];
        sb_ws_d[0]  = pop ? head[26:22] : 5'd0;

        if (pop) begin
            instr_out_d   = head;
            issue_valid_d = 1'b1;
            if (issued_q != CNT_MAX) begin
                issued_d = issued_q + 16'd1;
            end
        end
        if (stall_evt && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Storage carries no reset; occupancy is governed by the pointers and count alone.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            sb_vld_q      <= '0;
            sb_ws_q       <= '0;
            instr_out_q   <= BUBBLE;
            issue_valid_q <= 1'b0;
            issued_q      <= '0;
            stall_q       <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            sb_vld_q      <= sb_vld_d;
            sb_ws_q       <= sb_ws_d;
            instr_out_q   <= instr_out_d;
            issue_valid_q <= issue_valid_d;
            issued_q      <= issued_d;
            stall_q       <= stall_d;
        end
    end

    assign bus.in_ready     = !full;
    assign bus.instr_out    = instr_out_q;
    assign bus.issue_valid  = issue_valid_q;
    assign bus.fifo_count   = count_q;
    assign bus.issued_count = issued_q;
    assign bus.stall_count  = stall_q;
endmodule

// File: tb/tb_instr_issue_unit.sv
// Bench for instr_issue_unit: directed scenarios and random traffic against a
// register-last-write-time reference model, plus a long-hazard instance for saturation.
module tb_instr_issue_unit;
    localparam int DEPTH  = 8;
    localparam int HAZ    = 3;
    localparam int HAZ2   = 32;
    localparam int SAT_N  = 68000;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    instr_issue_unit_if #(.FIFO_DEPTH(DEPTH)) bus ();
    instr_issue_unit_if #(.FIFO_DEPTH(2))     bus2 ();

    instr_issue_unit #(.FIFO_DEPTH(DEPTH), .HAZ_DIST(HAZ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    instr_issue_unit #(.FIFO_DEPTH(2), .HAZ_DIST(HAZ2)) dut_sat (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: buffered instructions and the edge index of each register's last write.
    logic [31:0] mq[$];
    int          last_wr [32];
    int          cyc;
    int          m_issued, m_stall;
    logic [31:0] m_out;
    logic        m_vld;

    int e2;
    always @(posedge clk) begin
        if (rst2) e2 <= 0;
        else      e2 <= e2 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int r = 0; r < 32; r++) last_wr[r] = -1000;
        m_issued = 0;
        m_stall  = 0;
        m_out    = 32'h0;
        m_vld    = 1'b0;
    endtask

    function automatic logic m_hazard(input logic [31:0] h);
        int r1 = int'(h[21:17]);
        int r2 = int'(h[16:12]);
        return ((cyc - last_wr[r1]) < HAZ) || (!h[28] && ((cyc - last_wr[r2]) < HAZ));
    endfunction

    task automatic model_step(input logic v, input logic [31:0] ins, input logic r, input logic rs);
        logic ready;
        cyc++;
        if (rs) begin
            model_reset();
            return;
        end
        ready = (mq.size() < DEPTH);
        m_out = 32'h0;
        m_vld = 1'b0;
        if (r && mq.size() > 0) begin
            if (!m_hazard(mq[0])) begin
                m_out = mq.pop_front();
                m_vld = 1'b1;
                if (m_out[27]) last_wr[int'(m_out[26:22])] = cyc;
                if (m_issued < 65535) m_issued++;
            end else begin
                if (m_stall < 65535) m_stall++;
            end
        end
        if (v && ready) mq.push_back(ins);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".instr_out"}, bus.instr_out, m_out);
        chk({tag, ".issue_valid"}, 32'(bus.issue_valid), 32'(m_vld));
        chk({tag, ".fifo_count"}, 32'(bus.fifo_count), 32'(mq.size()));
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(mq.size() < DEPTH));
        chk({tag, ".issued"}, 32'(bus.issued_count), 32'(m_issued));
        chk({tag, ".stalls"}, 32'(bus.stall_count), 32'(m_stall));
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic r, input logic rs,
                        input string tag);
        bus.in_valid = v;
        bus.in_instr = ins;
        bus.run      = r;
        rst          = rs;
        @(posedge clk);
        model_step(v, ins, r, rs);
        #1;
        check_all(tag);
    endtask

    function automatic int sat_issued(input int n);
        return (n >= 2) ? ((n - 2) / HAZ2 + 1) : 0;
    endfunction

    function automatic int sat_stalls(input int n);
        int s = (n >= 2) ? (n - 1 - sat_issued(n)) : 0;
        return (s > 65535) ? 65535 : s;
    endfunction

    initial begin
        logic [31:0] ri;
        int          n;
        cyc = 0;
        model_reset();
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'h0;
        bus.run       = 1'b0;
        rst           = 1'b1;
        rst2          = 1'b1;
        bus2.in_valid = 1'b1;
        bus2.in_instr = 32'h0842_0000;
        bus2.run      = 1'b1;

        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, "reset");
        rst2 = 1'b0;
        chk("reset.instr_out", bus.instr_out, 32'h0);
        chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset.fifo_count", 32'(bus.fifo_count), 32'd0);

        // Independent pair issues back to back.
        step(1'b1, 32'h0A40_0000, 1'b1, 1'b0, "indep");
        step(1'b1, 32'h1842_0000, 1'b1, 1'b0, "indep");
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0, "indep");
        chk("indep.stall_count", 32'(bus.stall_count), 32'd0);
        chk("indep.issued_count", 32'(bus.issued_count), 32'd2);

        // Read-after-write: two bubbles between writer and reader.
        step(1'b0, 32'h0, 1'b0, 1'b1, "raw.rst");
        step(1'b1, 32'h0840_0000, 1'b1, 1'b0, "raw");
        step(1'b1, 32'h0002_0000, 1'b1, 1'b0, "raw");
        chk("raw.first", bus.instr_out, 32'h0840_0000);
        step(1'b0, 32'h0, 1'b1, 1'b0, "raw");
        chk("raw.bubble1", bus.instr_out, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, "raw");
        chk("raw.bubble2", bus.instr_out, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, "raw");
        chk("raw.second", bus.instr_out, 32'h0002_0000);
        chk("raw.stall_count", 32'(bus.stall_count), 32'd2);

        // Immediate operand bits alias the second read field but must not stall.
        step(1'b0, 32'h0, 1'b0, 1'b1, "imm.rst");
        step(1'b1, 32'h0840_0000, 1'b1, 1'b0, "imm");
        step(1'b1, 32'h1000_1000, 1'b1, 1'b0, "imm");
        step(1'b0, 32'h0, 1'b1, 1'b0, "imm");
        chk("imm.second", bus.instr_out, 32'h1000_1000);
        chk("imm.stall_count", 32'(bus.stall_count), 32'd0);

        // Fill to capacity with issue disabled, then drain in order.
        step(1'b0, 32'h0, 1'b0, 1'b1, "full.rst");
        for (int i = 0; i < 9; i++) step(1'b1, 32'h2000_0000 | 32'(i), 1'b0, 1'b0, "full.fill");
        chk("full.fifo_count", 32'(bus.fifo_count), 32'd8);
        chk("full.in_ready", 32'(bus.in_ready), 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0, "full.drain");
        chk("full.first", bus.instr_out, 32'h2000_0000);
        chk("full.ready_after_pop", 32'(bus.in_ready), 32'd1);
        for (int i = 1; i < 9; i++) step(1'b0, 32'h0, 1'b1, 1'b0, "full.drain");
        chk("full.issued_count", 32'(bus.issued_count), 32'd8);

        // Reset with entries buffered and a push pending.
        step(1'b0, 32'h0, 1'b0, 1'b1, "midrst.rst");
        for (int i = 0; i < 5; i++) step(1'b1, 32'h4000_0000 | 32'(i), 1'b0, 1'b0, "midrst.fill");
        step(1'b1, 32'h1234_5678, 1'b1, 1'b1, "midrst.hit");
        chk("midrst.fifo_count", 32'(bus.fifo_count), 32'd0);
        chk("midrst.issue_valid", 32'(bus.issue_valid), 32'd0);
        chk("midrst.counters", {bus.issued_count, bus.stall_count}, 32'h0);
        step(1'b1, 32'h0000_0001, 1'b0, 1'b0, "midrst.after");

        // Random traffic over a small register set to provoke frequent hazards.
        step(1'b0, 32'h0, 1'b0, 1'b1, "rand.rst");
        for (int i = 0; i < 400; i++) begin
            ri        = $urandom;
            ri[26:22] = 5'($urandom_range(0, 3));
            ri[21:17] = 5'($urandom_range(0, 3));
            ri[16:12] = 5'($urandom_range(0, 3));
            step(1'($urandom_range(0, 1)), ri, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 199) == 0), "rand");
        end

        // Long-hazard instance: counters follow the issue/stall cadence, then stalls saturate.
        @(posedge clk);
        #1;
        n = e2;
        chk("sat.mid_issued", 32'(bus2.issued_count), 32'(sat_issued(n)));
        chk("sat.mid_stalls", 32'(bus2.stall_count), 32'(sat_stalls(n)));
        while (e2 < SAT_N) begin
            @(posedge clk);
            #1;
        end
        n = e2;
        chk("sat.stall_count", 32'(bus2.stall_count), 32'h0000_FFFF);
        chk("sat.issued_count", 32'(bus2.issued_count), 32'(sat_issued(n)));
        repeat (40) @(posedge clk);
        #1;
        chk("sat.stall_hold", 32'(bus2.stall_count), 32'h0000_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
